shift_issue: RTL and testbench
==============================

SHIFT_ISSUE -- requirements
Module: shift_issue

Interface
REQ-001 The block SHALL have parameter CNT_W, default 16, giving the width of the completed-operation counter.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, a synchronous, active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the upstream presents a shift instruction.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts the instruction this cycle.
REQ-006 The block SHALL have port funct, input, 6, the R-type function field.
REQ-007 The block SHALL have ports shamt, input, 5 (immediate shift amount), rs_val, input, 32 (variable amount source), rt_val, input, 32 (value to shift) and rd, input, 5 (destination tag).
REQ-008 The block SHALL have ports sh_value, output, 32, sh_op, output, 2 and sh_amt, output, 5, which drive the combinational Shifter.
REQ-009 The block SHALL have port sh_result, input, 32, the combinational result returned by the Shifter.
REQ-010 The block SHALL have ports out_valid, output, 1, out_ready, input, 1, out_result, output, 32, out_rd, output, 5 and out_illegal, output, 1.
REQ-011 The block SHALL have port done_count, output, CNT_W, the count of completed output handshakes.

Function
REQ-012 Decode SHALL use sh_op 00 for logical right, 10 for logical left and 01 for arithmetic right, with sh_value = rt_val in every case.
REQ-013 Decode SHALL map funct 000000 (sll), 000010 (srl) and 000011 (sra) to ops 10, 00 and 01 respectively, with amt = shamt.
REQ-014 Decode SHALL map funct 000100 (sllv), 000110 (srlv) and 000111 (srav) to ops 10, 00 and 01 respectively, with amt = rs_val[4:0].
REQ-015 Any other funct SHALL be marked illegal and SHALL complete with out_result = 0 and out_illegal = 1.
REQ-016 The block SHALL have a two-stage pipeline: S1 is the issue register holding the decoded op, amt, value, rd, illegal flag and valid bit; S2 is the result register.
REQ-017 sh_value, sh_op and sh_amt SHALL be driven directly from the S1 registers, and SHALL be 0 when S1 is empty.
REQ-018 The advance condition SHALL be adv2 = !s2_valid || out_ready.
REQ-019 in_ready SHALL equal !s1_valid || adv2 and SHALL be purely combinational, with no dependence on in_valid.
REQ-020 An input handshake (in_valid && in_ready) SHALL load S1 on that edge.
REQ-021 When s1_valid && adv2, S2 SHALL capture sh_result (or 0 if illegal), rd and the illegal flag on that edge.
REQ-022 An instruction accepted at edge N SHALL have out_valid = 1 after edge N+1, giving a latency of 2 edges.
REQ-023 Throughput SHALL be 1 per cycle while out_ready = 1.
REQ-024 While out_valid && !out_ready, out_result, out_rd and out_illegal SHALL be held stable and S1 SHALL hold.
REQ-025 When S1 is full and stalled, in_ready SHALL be 0.
REQ-026 Simultaneous S1 load and S1 advance in the same edge SHALL be legal, with no bubble and no loss.
REQ-027 S2 SHALL clear its valid bit on an output handshake when no new S1 data advances.
REQ-028 done_count SHALL increment by 1 on each out_valid && out_ready edge, including illegal ops, and SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-029 On reset, the S1 valid bit, the S2 valid bit, out_result, out_rd, out_illegal, done_count and every S1 register SHALL become 0.
REQ-030 Consequently, after reset, sh_value, sh_op and sh_amt SHALL be 0 and in_ready SHALL be 1.
REQ-031 Reset SHALL take priority over any handshake in the same cycle, and in-flight ops SHALL be discarded without counting.

Verification
REQ-032 The bench SHALL check: srl, rt=0xFF000000, shamt=4, out_ready=1 -> out_result=0x0FF00000 two edges after acceptance, done_count=1.
REQ-033 The bench SHALL check: sra, rt=0xFF000000, shamt=4 -> 0xFFF00000; sll, rt=0x000000FF, shamt=5 -> 0x00001FE0.
REQ-034 The bench SHALL check: srav, rs=0x00000023, rt=0x80000000 -> sh_amt=3, out_result=0xF0000000.
REQ-035 The bench SHALL check: funct=100000 -> out_illegal=1, out_result=0, done_count increments.
REQ-036 The bench SHALL check back-pressure: 3 back-to-back ops with out_ready=0 -> in_ready drops after the 2nd acceptance and the outputs stay stable. Raising out_ready SHALL then drain the results in order, one per cycle, with no loss.
REQ-037 The bench SHALL check reset mid-stream: reset asserted with S1 and S2 full -> next cycle out_valid=0, done_count=0, in_ready=1.

Source files
------------

// File: rtl/shift_issue.sv
// Two-stage issue pipeline for MIPS R-type shift instructions.
// S1 decodes and feeds an external combinational shifter; S2 holds the result.
module shift_issue #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [4:0]       shamt,
  input  logic [31:0]      rs_val,
  input  logic [31:0]      rt_val,
  input  logic [4:0]       rd,
  output logic [31:0]      sh_value,
  output logic [1:0]       sh_op,
  output logic [4:0]       sh_amt,
  input  logic [31:0]      sh_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [4:0]       out_rd,
  output logic             out_illegal,
  output logic [CNT_W-1:0] done_count
);

  localparam logic [1:0] OP_SRL = 2'b00;
  localparam logic [1:0] OP_SRA = 2'b01;
  localparam logic [1:0] OP_SLL = 2'b10;

  localparam logic [5:0] F_SLL  = 6'b000000;
  localparam logic [5:0] F_SRL  = 6'b000010;
  localparam logic [5:0] F_SRA  = 6'b000011;
  localparam logic [5:0] F_SLLV = 6'b000100;
  localparam logic [5:0] F_SRLV = 6'b000110;
  localparam logic [5:0] F_SRAV = 6'b000111;

  // Handshakes: a transfer happens on an edge where valid && ready are both 1.
  // ready never depends on valid on the same side; valid, once raised by the
  // block, holds with stable payload until the matching ready is seen.

  logic        s1_valid;
  logic [1:0]  s1_op;
  logic [4:0]  s1_amt;
  logic [31:0] s1_value;
  logic [4:0]  s1_rd;
  logic        s1_illegal;

  logic        s2_valid;
  logic        adv2;
  logic        in_fire;
  logic        s1_adv;
  logic        out_fire;

  logic [1:0]  dec_op;
  logic [4:0]  dec_amt;
  logic        dec_illegal;
  logic        unused_rs;

  assign unused_rs = ^rs_val[31:5];

  assign adv2     = !s2_valid || out_ready;
  assign in_ready = !s1_valid || adv2;
  assign in_fire  = in_valid && in_ready;
  assign s1_adv   = s1_valid && adv2;
  assign out_valid = s2_valid;
  assign out_fire = s2_valid && out_ready;

  always_comb begin
    dec_op      = OP_SRL;
    dec_amt     = 5'd0;
    dec_illegal = 1'b0;
    case (funct)
      F_SLL:  begin dec_op = OP_SLL; dec_amt = shamt;       end
      F_SRL:  begin dec_op = OP_SRL; dec_amt = shamt;       end
      F_SRA:  begin dec_op = OP_SRA; dec_amt = shamt;       end
      F_SLLV: begin dec_op = OP_SLL; dec_amt = rs_val[4:0]; end
      F_SRLV: begin dec_op = OP_SRL; dec_amt = rs_val[4:0]; end
      F_SRAV: begin dec_op = OP_SRA; dec_amt = rs_val[4:0]; end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Shifter sees zeros whenever S1 is empty, so it never toggles on stale data.
  assign sh_value = s1_valid ? s1_value : 32'd0;
  assign sh_op    = s1_valid ? s1_op    : 2'd0;
  assign sh_amt   = s1_valid ? s1_amt   : 5'd0;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_op      <= 2'd0;
      s1_amt     <= 5'd0;
      s1_value   <= 32'd0;
      s1_rd      <= 5'd0;
      s1_illegal <= 1'b0;
    end else if (in_fire) begin
      s1_valid   <= 1'b1;
      s1_op      <= dec_op;
      s1_amt     <= dec_amt;
      s1_value   <= rt_val;
      s1_rd      <= rd;
      s1_illegal <= dec_illegal;
    end else if (s1_adv) begin
      s1_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid    <= 1'b0;
      out_result  <= 32'd0;
      out_rd      <= 5'd0;
      out_illegal <= 1'b0;
    end else if (s1_adv) begin
      s2_valid    <= 1'b1;
      out_result  <= s1_illegal ? 32'd0 : sh_result;
      out_rd      <= s1_rd;
      out_illegal <= s1_illegal;
    end else if (out_fire) begin
      s2_valid    <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      done_count <= '0;
    end else if (out_fire) begin
      done_count <= done_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_shift_issue.sv
// Self-checking bench for shift_issue: directed shift cases, back-pressure,
// mid-stream reset and a randomized stream checked through an expected queue.
module tb_shift_issue;

  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [5:0]       funct;
  logic [4:0]       shamt;
  logic [31:0]      rs_val;
  logic [31:0]      rt_val;
  logic [4:0]       rd;
  logic [31:0]      sh_value;
  logic [1:0]       sh_op;
  logic [4:0]       sh_amt;
  logic [31:0]      sh_result;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_result;
  logic [4:0]       out_rd;
  logic             out_illegal;
  logic [CNT_W-1:0] done_count;

  int tests_run;
  int tests_failed;

  logic [37:0]      exp_q[$];
  logic [CNT_W-1:0] exp_done;

  shift_issue #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .funct(funct), .shamt(shamt), .rs_val(rs_val), .rt_val(rt_val), .rd(rd),
    .sh_value(sh_value), .sh_op(sh_op), .sh_amt(sh_amt), .sh_result(sh_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_illegal(out_illegal), .done_count(done_count)
  );

  // Environment model of the external combinational shifter.
  always_comb begin
    case (sh_op)
      2'b00:   sh_result = sh_value >> sh_amt;
      2'b10:   sh_result = sh_value << sh_amt;
      2'b01:   sh_result = 32'($signed(sh_value) >>> sh_amt);
      default: sh_result = 32'd0;
    endcase
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Instruction-level reference: {illegal, rd, result}.
  function automatic logic [37:0] model(input logic [5:0] f, input logic [4:0] sa,
                                        input logic [31:0] rs, input logic [31:0] rt,
                                        input logic [4:0] d);
    logic [31:0] r;
    logic        ill;
    ill = 1'b0;
    case (f)
      6'b000000: r = rt << sa;
      6'b000010: r = rt >> sa;
      6'b000011: r = 32'($signed(rt) >>> sa);
      6'b000100: r = rt << rs[4:0];
      6'b000110: r = rt >> rs[4:0];
      6'b000111: r = 32'($signed(rt) >>> rs[4:0]);
      default: begin r = 32'd0; ill = 1'b1; end
    endcase
    return {ill, d, r};
  endfunction

  // ---------------- scoreboard ----------------
  // Inputs only change at posedge+1, so values seen at negedge are what the
  // next rising edge samples.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      exp_done = '0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_output", 64'd1, 64'd0);
        end else begin
          check("sb_output", {26'd0, out_illegal, out_rd, out_result}, {26'd0, exp_q.pop_front()});
        end
        check("sb_done_count", 64'(done_count), 64'(exp_done));
        exp_done = exp_done + 1'b1;
      end
      if (in_valid && in_ready)
        exp_q.push_back(model(funct, shamt, rs_val, rt_val, rd));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [5:0] f, input logic [4:0] sa, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [4:0] d, input bit release_bp);
    bit acc;
    int n;
    funct = f; shamt = sa; rs_val = rs; rt_val = rt; rd = d;
    in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
      if (!acc && release_bp) out_ready = 1'b1;
    end while (!acc && n < 50);
    if (!acc) check("send_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  // One op through an idle pipeline with out_ready=1: check shifter drive,
  // result two edges after acceptance, and count one edge later.
  task automatic run_one(input string tag, input logic [5:0] f, input logic [4:0] sa,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [4:0] d,
                         input logic [1:0] want_op, input logic [4:0] want_amt,
                         input logic [31:0] want_res, input logic want_ill);
    logic [CNT_W-1:0] want_cnt;
    want_cnt = exp_done + 1'b1;
    out_ready = 1'b1;
    send(f, sa, rs, rt, d, 1'b0);
    if (!want_ill) begin
      check({tag, "_sh_value"}, 64'(sh_value), 64'(rt));
      check({tag, "_sh_op"},    64'(sh_op),    64'(want_op));
      check({tag, "_sh_amt"},   64'(sh_amt),   64'(want_amt));
    end
    check({tag, "_not_early"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    check({tag, "_out_valid"},   64'(out_valid),   64'd1);
    check({tag, "_out_result"},  64'(out_result),  64'(want_res));
    check({tag, "_out_rd"},      64'(out_rd),      64'(d));
    check({tag, "_out_illegal"}, 64'(out_illegal), 64'(want_ill));
    @(posedge clk); #1;
    check({tag, "_done_count"},  64'(done_count),  64'(want_cnt));
    check({tag, "_drained"},     64'(out_valid),   64'd0);
  endtask

  // ---------------- main stimulus ----------------
  logic [5:0]  ftab [8];
  logic [31:0] held;
  int          wait_n;

  initial begin
    tests_run = 0; tests_failed = 0; exp_done = '0;
    ftab[0] = 6'b000000; ftab[1] = 6'b000010; ftab[2] = 6'b000011; ftab[3] = 6'b000100;
    ftab[4] = 6'b000110; ftab[5] = 6'b000111; ftab[6] = 6'b100000; ftab[7] = 6'b000001;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    funct = '0; shamt = '0; rs_val = '0; rt_val = '0; rd = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_done_count", 64'(done_count), 64'd0);
    check("rst_in_ready",   64'(in_ready),   64'd1);
    check("rst_sh_value",   64'(sh_value),   64'd0);
    check("rst_sh_op",      64'(sh_op),      64'd0);
    check("rst_sh_amt",     64'(sh_amt),     64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);

    run_one("srl",  6'b000010, 5'd4, 32'h0, 32'hFF000000, 5'd1, 2'b00, 5'd4, 32'h0FF00000, 1'b0);
    check("srl_count_is_1", 64'(done_count), 64'd1);
    run_one("sra",  6'b000011, 5'd4, 32'h0, 32'hFF000000, 5'd2, 2'b01, 5'd4, 32'hFFF00000, 1'b0);
    run_one("sll",  6'b000000, 5'd5, 32'h0, 32'h000000FF, 5'd3, 2'b10, 5'd5, 32'h00001FE0, 1'b0);
    run_one("srav", 6'b000111, 5'd9, 32'h00000023, 32'h80000000, 5'd4, 2'b01, 5'd3, 32'hF0000000, 1'b0);
    run_one("srlv", 6'b000110, 5'd0, 32'hFFFFFFFF, 32'h80000000, 5'd5, 2'b00, 5'd31, 32'h00000001, 1'b0);
    run_one("ill",  6'b100000, 5'd3, 32'h1, 32'hDEADBEEF, 5'd6, 2'b00, 5'd0, 32'h0, 1'b1);

    // Back-pressure: A and B fill both stages, C waits at the input.
    out_ready = 1'b0;
    send(6'b000000, 5'd1, 32'h0, 32'h00000011, 5'd10, 1'b0);
    send(6'b000010, 5'd2, 32'h0, 32'h00000400, 5'd11, 1'b0);
    check("bp_in_ready_low", 64'(in_ready),  64'd0);
    check("bp_out_valid",    64'(out_valid), 64'd1);
    check("bp_first_result", 64'(out_result), 64'h22);
    held = out_result;
    funct = 6'b000100; shamt = 5'd0; rs_val = 32'd4; rt_val = 32'h00000003; rd = 5'd12;
    in_valid = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("bp_hold_result", 64'(out_result), 64'(held));
      check("bp_hold_rd",     64'(out_rd),     64'd10);
      check("bp_hold_ready",  64'(in_ready),   64'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_in_ready_back", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_drain_b_valid", 64'(out_valid),  64'd1);
    check("bp_drain_b",       64'(out_result), 64'h100);
    @(posedge clk); #1;
    check("bp_drain_c_valid", 64'(out_valid),  64'd1);
    check("bp_drain_c",       64'(out_result), 64'h30);
    @(posedge clk); #1;
    check("bp_drain_empty",   64'(out_valid),  64'd0);

    // Reset with both stages full.
    out_ready = 1'b0;
    send(6'b000010, 5'd1, 32'h0, 32'h00000008, 5'd20, 1'b0);
    send(6'b000010, 5'd1, 32'h0, 32'h00000010, 5'd21, 1'b0);
    check("mid_full_ready", 64'(in_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("mid_rst_out_valid",  64'(out_valid),  64'd0);
    check("mid_rst_done_count", 64'(done_count), 64'd0);
    check("mid_rst_in_ready",   64'(in_ready),   64'd1);
    check("mid_rst_sh_value",   64'(sh_value),   64'd0);
    out_ready = 1'b1;

    // Random stream with random back-pressure; count wraps at 16.
    for (int i = 0; i < 60; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
      send(ftab[$urandom_range(0, 7)], 5'($urandom_range(0, 31)), $urandom(), $urandom(),
           5'($urandom_range(0, 31)), 1'b1);
    end
    out_ready = 1'b1;
    wait_n = 0;
    while ((exp_q.size() != 0 || out_valid) && wait_n < 20) begin
      @(posedge clk); #1;
      wait_n++;
    end
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_count",       64'(done_count),   64'(exp_done));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
